jk_from_d_counter: RTL
======================

JK_FROM_D_COUNTER -- requirements
Module: jk_from_d_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst  input  1  reset; synchronous, active-high, sampled on rising clk.
REQ-004 SHALL provide port: en  input  1  count enable.
REQ-005 SHALL provide port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL provide port: load  input  1  synchronous parallel load request.
REQ-007 SHALL provide port: load_val  input  WIDTH  value loaded when load=1.
REQ-008 SHALL provide port: q  output  WIDTH  registered count.
REQ-009 SHALL provide port: qb  output  WIDTH  bitwise complement of q, always ~q.
REQ-010 SHALL provide port: tc  output  1  terminal count, combinational.

Function
REQ-011 Every state bit SHALL be a JK cell built from one D flop, with next state d = (j & ~q) | (~k & q).
REQ-012 JK codes SHALL behave as follows: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-013 Per-edge priority SHALL be rst > load > en > hold.
REQ-014 When load=1, bit i SHALL receive j=load_val[i] and k=~load_val[i]; q SHALL equal load_val one edge later, regardless of en and up.
REQ-015 When load=0, en=1 and up=1, bit 0 SHALL toggle, and bit i>0 SHALL toggle only if q[i-1:0] are all 1; otherwise the code SHALL be 00.
REQ-016 When load=0, en=1 and up=0, bit 0 SHALL toggle, and bit i>0 SHALL toggle only if q[i-1:0] are all 0.
REQ-017 When load=0 and en=0, all bits SHALL receive code 00, so q holds.
REQ-018 Count latency SHALL be one clk edge; q SHALL change only on rising clk.
REQ-019 tc SHALL equal en & (up ? (q == all-ones) : (q == 0)).
REQ-020 Without saturation, count SHALL wrap modulo 2^WIDTH: all-ones +1 gives 0, and 0 -1 gives all-ones.
REQ-021 A change of up between edges SHALL take effect at the next edge with no extra latency.
REQ-022 q SHALL never be X or Z after the first reset edge.

Reset
REQ-023 On a rst edge, q SHALL become 0 and qb SHALL become all-ones, overriding load and en.
REQ-024 Reset mid-count SHALL abandon the count; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-025 After reset, tc SHALL be 0 if up=1 or en=0, and SHALL be 1 if up=0 and en=1.

Configuration
REQ-026 Macro JK_CNT_SATURATE_EN, when defined, SHALL force code 00 on all bits whenever tc=1 and load=0, so the count holds at the bound instead of wrapping.
REQ-027 With JK_CNT_SATURATE_EN undefined, the wrap behaviour of REQ-020 SHALL apply; load and reset behaviour SHALL be identical in both builds.

Structure
REQ-028 Shared package jk_cnt_pkg SHALL hold the JK code enum (JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11) and the constant JK_CNT_DEFAULT_WIDTH=4.
REQ-029 Sub-module jk_cell (ports clk, rst, j, k, q, qb) SHALL implement one D-flop-based JK bit; the top SHALL instantiate WIDTH of them via generate, and SHALL hold excitation and tc logic only.

Verification
REQ-030 Reset and count: rst=1 for 2 edges, then en=1, up=1 for 5 edges -> q=0, qb=4'hF after reset; then q=1,2,3,4,5; tc=0 throughout.
REQ-031 Wrap (no macro): load 4'hE, then en=1, up=1 -> q=F with tc=1, then q=0 with tc=0; down from 0 -> q=F.
REQ-032 Saturation (macro defined): load 4'hE, then en=1, up=1 for 4 edges -> q=F,F,F,F with tc=1; switch up=0 -> q=E on the next edge.
REQ-033 Priority: load=1, load_val=4'h9, en=1, up=0 on the same edge -> q=9; asserting rst with load=1 on the same edge -> q=0.
REQ-034 Hold and mid-count reset: count to 6, en=0 for 3 edges -> q stays 6; pulse rst for one edge while en=1 -> q=0, then q=1 on the next edge.
REQ-035 Invariant checked every cycle: qb == ~q; q contains no X after the first reset.

Source files
------------

// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK-from-D counter: JK excitation codes and default width.
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_code_e;

  localparam int unsigned JK_CNT_DEFAULT_WIDTH = 4;

endpackage : jk_cnt_pkg

// File: rtl/jk_cell.sv
// One JK storage bit built from a single D flop; synchronous active-high reset clears it.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic r_q;
  logic w_d;

  assign w_d = (j & ~r_q) | (~k & r_q);

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= w_d;
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule : jk_cell

// File: rtl/jk_from_d_counter.sv
// Up/down counter with parallel load, built from WIDTH jk_cell bits.
// Optional macro JK_CNT_SATURATE_EN holds the count at its bound instead of wrapping.
module jk_from_d_counter
  import jk_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = JK_CNT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  jk_code_e          w_code [WIDTH];
  logic [WIDTH-1:0]  w_j;
  logic [WIDTH-1:0]  w_k;
  logic [WIDTH-1:0]  w_q;
  logic [WIDTH-1:0]  w_qb;
  logic              w_sat;

  assign tc = en & (up ? (&w_q) : ~(|w_q));

`ifdef JK_CNT_SATURATE_EN
  assign w_sat = tc;
`else
  assign w_sat = 1'b0;
`endif

  // w_ones/w_zeros track whether all lower bits are 1/0, forming the ripple toggle enables.
  always_comb begin : p_excite
    logic w_ones;
    logic w_zeros;
    w_ones  = 1'b1;
    w_zeros = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_code[i] = JK_HOLD;
      if (load) begin
        w_code[i] = load_val[i] ? JK_SET : JK_CLR;
      end else if (en && !w_sat) begin
        if (up ? w_ones : w_zeros) w_code[i] = JK_TGL;
      end
      w_ones  = w_ones  &  w_q[i];
      w_zeros = w_zeros & ~w_q[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      assign w_j[g] = w_code[g][1];
      assign w_k[g] = w_code[g][0];
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (w_j[g]),
        .k   (w_k[g]),
        .q   (w_q[g]),
        .qb  (w_qb[g])
      );
    end
  endgenerate

  assign q  = w_q;
  assign qb = w_qb;

endmodule : jk_from_d_counter
